// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter in front of one picorv32 native memory port.
// Winning request is registered onto the slave port; a watchdog aborts any
// transaction the slave never acknowledges and returns ERR_RDATA instead.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout,
  output logic        timeout_seen
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        gnt_q;
  logic        last_q;
  logic [15:0] wdog_q;

  logic        gnt_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] resp_d;

  // Arbitration choice: a lone requester wins, a tie goes to whoever was not last.
  always_comb begin
    gnt_d   = m1_valid & (~m0_valid | ~last_q);
    addr_d  = gnt_d ? m1_addr  : m0_addr;
    wdata_d = gnt_d ? m1_wdata : m0_wdata;
    wstrb_d = gnt_d ? m1_wstrb : m0_wstrb;
    // Real slave data beats the watchdog when both land in the same cycle.
    resp_d  = s_ready ? s_rdata : ERR_RDATA;
  end

  // Arbiter FSM; every output is a register so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      wdog_q       <= '0;
      s_valid      <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      timeout      <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            gnt_q   <= gnt_d;
            s_addr  <= addr_d;
            s_wdata <= wdata_d;
            s_wstrb <= wstrb_d;
            s_valid <= 1'b1;
            wdog_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Completion (real or aborted) proceeds even if the master dropped valid.
          if (s_ready || wdog_q == WDOG_LAST) begin
            if (gnt_q) begin
              m1_rdata <= resp_d;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= resp_d;
              m0_ready <= 1'b1;
            end
            if (!s_ready) begin
              timeout      <= 1'b1;
              timeout_seen <= 1'b1;
            end
            s_valid <= 1'b0;
            last_q  <= gnt_q;
            state_q <= RESP;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        // One ready cycle lets the master drop valid before we arbitrate again.
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter with TIMEOUT = 8.
module tb_picorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        timeout, timeout_seen;

  int pass_cnt = 0;
  int total_cnt = 0;

  picorv32_mem_arbiter #(.TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout(timeout), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    total_cnt++; if (s_valid !== 1'b0) $display("FAIL rst_s_valid got %0b want 0", s_valid); else pass_cnt++;
    total_cnt++; if (s_addr !== 32'h0) $display("FAIL rst_s_addr got %h want 0", s_addr); else pass_cnt++;
    total_cnt++; if (s_wstrb !== 4'h0) $display("FAIL rst_s_wstrb got %h want 0", s_wstrb); else pass_cnt++;
    total_cnt++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL rst_ready got %b want 00", {m0_ready, m1_ready}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h0) $display("FAIL rst_m0_rdata got %h want 0", m0_rdata); else pass_cnt++;
    total_cnt++; if ({timeout, timeout_seen} !== 2'b00) $display("FAIL rst_timeout got %b want 00", {timeout, timeout_seen}); else pass_cnt++;
    resetn = 1'b1;
  endtask

  // Both masters hold valid; slave ready is held high so each grant completes in its first BUSY cycle.
  task automatic test_round_robin();
    logic exp_gnt;
    logic [31:0] exp_data;
    m0_valid = 1'b1; m0_addr = 32'h1000; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h1004; m1_wstrb = 4'h0;
    s_ready  = 1'b1;
    exp_gnt  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data = 32'hA000_0000 + 32'(i);
      s_rdata  = exp_data;
      tick();
      total_cnt++; if (s_valid !== 1'b1) $display("FAIL rr_s_valid[%0d] got %0b want 1", i, s_valid); else pass_cnt++;
      total_cnt++; if (s_addr !== (exp_gnt ? 32'h1004 : 32'h1000)) $display("FAIL rr_grant_addr[%0d] got %h want %h", i, s_addr, exp_gnt ? 32'h1004 : 32'h1000); else pass_cnt++;
      tick();
      total_cnt++; if ({m1_ready, m0_ready} !== (exp_gnt ? 2'b10 : 2'b01)) $display("FAIL rr_ready[%0d] got %b want %b", i, {m1_ready, m0_ready}, exp_gnt ? 2'b10 : 2'b01); else pass_cnt++;
      total_cnt++; if ((exp_gnt ? m1_rdata : m0_rdata) !== exp_data) $display("FAIL rr_rdata[%0d] got %h want %h", i, exp_gnt ? m1_rdata : m0_rdata, exp_data); else pass_cnt++;
      tick();
      total_cnt++; if ({s_valid, m1_ready, m0_ready} !== 3'b000) $display("FAIL rr_idle_gap[%0d] got %b want 000", i, {s_valid, m1_ready, m0_ready}); else pass_cnt++;
      exp_gnt = ~exp_gnt;
    end
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_single_read();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    tick();
    total_cnt++; if (s_valid !== 1'b1 || s_addr !== 32'h100) $display("FAIL rd_request got v=%0b a=%h want v=1 a=00000100", s_valid, s_addr); else pass_cnt++;
    tick();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    total_cnt++; if ({m1_ready, m0_ready, s_valid} !== 3'b010) $display("FAIL rd_ready got m1r/m0r/sv=%b want 010", {m1_ready, m0_ready, s_valid}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1234_5678) $display("FAIL rd_data got %h want 12345678", m0_rdata); else pass_cnt++;
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h5555_5555;
    tick();
    total_cnt++; if (m0_ready !== 1'b0) $display("FAIL rd_single_pulse got %0b want 0", m0_ready); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1234_5678) $display("FAIL rd_data_hold got %h want 12345678", m0_rdata); else pass_cnt++;
  endtask

  task automatic test_write();
    m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h2000, 32'hCAFE_F00D, 4'b0011})
        $display("FAIL wr_payload[%0d] got v=%0b a=%h d=%h s=%b want v=1 a=00002000 d=cafef00d s=0011", i, s_valid, s_addr, s_wdata, s_wstrb); else pass_cnt++;
    end
    s_ready = 1'b1; s_rdata = 32'h0000_0042;
    tick();
    total_cnt++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL wr_ready got %b want 10", {m1_ready, m0_ready}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1234_5678) $display("FAIL wr_other_rdata got %h want 12345678", m0_rdata); else pass_cnt++;
    m1_valid = 1'b0; s_ready = 1'b0;
    tick();
    total_cnt++; if (m1_ready !== 1'b0) $display("FAIL wr_single_pulse got %0b want 0", m1_ready); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int cnt;
    m0_valid = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'h0;
    s_ready = 1'b0;
    cnt = 0;
    tick();
    while (s_valid === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    total_cnt++; if (cnt !== 8) $display("FAIL to_busy_cycles got %0d want 8", cnt); else pass_cnt++;
    total_cnt++; if ({timeout, timeout_seen, m0_ready} !== 3'b111) $display("FAIL to_pulse got to/seen/m0r=%b want 111", {timeout, timeout_seen, m0_ready}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata got %h want deadbeef", m0_rdata); else pass_cnt++;
    m0_valid = 1'b0;
    tick();
    total_cnt++; if ({timeout, timeout_seen, m0_ready} !== 3'b010) $display("FAIL to_after got to/seen/m0r=%b want 010", {timeout, timeout_seen, m0_ready}); else pass_cnt++;
    // Next request must be served normally.
    m1_valid = 1'b1; m1_addr = 32'h400; s_ready = 1'b1; s_rdata = 32'h7777_0001;
    tick();
    total_cnt++; if (s_valid !== 1'b1 || s_addr !== 32'h400) $display("FAIL to_next_req got v=%0b a=%h want v=1 a=00000400", s_valid, s_addr); else pass_cnt++;
    tick();
    total_cnt++; if ({m1_ready, timeout} !== 2'b10 || m1_rdata !== 32'h7777_0001) $display("FAIL to_next_resp got r/to=%b d=%h want 10 d=77770001", {m1_ready, timeout}, m1_rdata); else pass_cnt++;
    m1_valid = 1'b0; s_ready = 1'b0;
    tick();
  endtask

  task automatic test_ready_at_timeout();
    m0_valid = 1'b1; m0_addr = 32'h500; s_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total_cnt++; if (s_valid !== 1'b1) $display("FAIL rt_still_busy got %0b want 1", s_valid); else pass_cnt++;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    total_cnt++; if ({m0_ready, timeout} !== 2'b10) $display("FAIL rt_no_timeout got r/to=%b want 10", {m0_ready, timeout}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h0BAD_F00D) $display("FAIL rt_rdata got %h want 0badf00d", m0_rdata); else pass_cnt++;
    total_cnt++; if (timeout_seen !== 1'b1) $display("FAIL rt_seen got %0b want 1", timeout_seen); else pass_cnt++;
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
  endtask

  // last is m0 here, so a post-reset tie granting m0 proves last was reset to 1.
  task automatic test_reset_mid_busy();
    m1_valid = 1'b1; m1_addr = 32'h600; s_ready = 1'b0;
    tick();
    total_cnt++; if (s_valid !== 1'b1) $display("FAIL rb_busy got %0b want 1", s_valid); else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++; if (s_valid !== 1'b0 || s_addr !== 32'h0) $display("FAIL rb_async got v=%0b a=%h want v=0 a=0", s_valid, s_addr); else pass_cnt++;
    total_cnt++; if (timeout_seen !== 1'b0) $display("FAIL rb_seen_clear got %0b want 0", timeout_seen); else pass_cnt++;
    tick();
    total_cnt++; if ({m1_ready, m0_ready} !== 2'b00) $display("FAIL rb_no_ready got %b want 00", {m1_ready, m0_ready}); else pass_cnt++;
    m0_valid = 1'b1; m0_addr = 32'h700;
    resetn = 1'b1;
    tick();
    total_cnt++; if (s_valid !== 1'b1 || s_addr !== 32'h700) $display("FAIL rb_tie_m0 got v=%0b a=%h want v=1 a=00000700", s_valid, s_addr); else pass_cnt++;
    s_ready = 1'b1; s_rdata = 32'h0000_0700;
    tick();
    total_cnt++; if ({m1_ready, m0_ready} !== 2'b01) $display("FAIL rb_resp got %b want 01", {m1_ready, m0_ready}); else pass_cnt++;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at %0t, want completion earlier", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

Two-master arbiter that shares one picorv32-style native memory port between the CPU (master 0) and a debug/loader master (master 1). It sits between `picorv32_wrapper`'s core and its memory model. It grants round-robin, registers the winning request onto the slave port, and returns the slave response to the granted master. A watchdog completes any transaction the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 1024, slave cycles allowed per transaction before abort; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_valid, m1_valid  in  1  request valid; held with its payload until the matching ready.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_ready, m1_ready  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  read data; valid while the matching ready is high.
- s_valid  out  1  slave request valid.
- s_addr  out  32  registered request address.
- s_wdata  out  32  registered request write data.
- s_wstrb  out  4  registered request write strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data; sampled when s_ready is high.
- timeout  out  1  one-cycle pulse when a transaction is aborted.
- timeout_seen  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If no valid is asserted, stay in IDLE.
  - If only one master is valid, grant it.
  - If both are valid, grant the master that is not `last`. `last` is the most recently granted master and resets to 1, so m0 wins the first tie.
  - On a grant: latch addr, wdata and wstrb into s_*; set s_valid; clear the watchdog; record `gnt`; go to BUSY.
- BUSY:
  - s_valid is high and s_* are stable.
  - If s_ready: capture s_rdata into the granted m*_rdata, drop s_valid, set `last` = gnt, go to RESP.
  - Else, if watchdog == TIMEOUT-1: load ERR_RDATA, drop s_valid, pulse timeout, set timeout_seen, set `last` = gnt, go to RESP.
  - Else: increment the watchdog.
- RESP:
  - m{gnt}_ready is high for exactly this cycle; go to IDLE.
  - This cycle exists so the master can deassert valid before the next arbitration. No grant is made in RESP.
- The watchdog is a 16-bit counter. It counts only in BUSY and saturates logically at TIMEOUT-1.
- m*_rdata holds its last value between responses. The non-granted master's rdata is unchanged.
- If a master drops valid during BUSY (a protocol violation), the slave transaction still completes and the ready pulse is still issued.
- s_ready outside BUSY is ignored.
- When s_ready and the timeout condition coincide in the same cycle, s_ready wins: the real s_rdata is returned and there is no timeout pulse.

## Timing
- Reset values:
  - state = IDLE, gnt = 0, last = 1, watchdog = 0.
  - s_valid = 0; s_addr, s_wdata, s_wstrb = 0.
  - m0_ready, m1_ready = 0; m0_rdata, m1_rdata = 0.
  - timeout = 0, timeout_seen = 0.
- Reset takes effect immediately, including mid-transaction. Everything returns to reset values and the in-flight request is dropped without a ready pulse.
- Request valid in IDLE at cycle N -> s_valid high at N+1.
- s_ready at cycle M -> m_ready high and s_valid low at M+1 -> IDLE at M+2 -> earliest next s_valid at M+3.
- Minimum request-to-ready latency is 3 cycles (slave ready in the first BUSY cycle).
- Timeout: s_valid is high for exactly TIMEOUT cycles. timeout and m_ready are high one cycle after the last of those cycles.
- Outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single read: m0 requests addr 0x100, wstrb 0; slave returns ready at the 2nd BUSY cycle with rdata 0x12345678 -> s_addr = 0x100, m0_ready pulses once with m0_rdata = 0x12345678, m1_ready stays 0.
- Tie and round-robin: both masters hold valid for 4 transactions, slave ready after 1 cycle -> grants alternate m0, m1, m0, m1. No master is granted twice in a row, and the 3-cycle per-transaction spacing holds.
- Write pass-through: m1 writes 0xCAFEF00D to 0x2000 with wstrb 4'b0011 -> s_wdata, s_wstrb and s_addr match exactly for the whole BUSY period; m1_ready pulses once.
- Timeout: TIMEOUT = 8, slave never asserts ready -> s_valid high for exactly 8 cycles, m0_rdata = 0xDEADBEEF, timeout pulses once, timeout_seen stays 1. The next request proceeds normally.
- Ready at the timeout cycle: s_ready arrives in the 8th BUSY cycle (TIMEOUT = 8) -> real data is returned, timeout stays 0, timeout_seen is unchanged.
- Reset mid-BUSY: assert resetn low while s_valid is high -> s_valid drops asynchronously, no m_ready pulse occurs, and the first grant after release goes to m0 on a tie.
